// File: rtl/mac_fp_dot_sequencer.sv
// Dot-product sequencer around one MAC_FP instance: feeds operand pairs with the
// running accumulator on IN3, captures each result after the MAC latency, returns the sum.
module mac_fp_dot_sequencer #(
  parameter int PARM_RM = 3,
  parameter int MAC_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [1:0]         mode,
  input  logic [PARM_RM-1:0] rm,
  input  logic [31:0]        init_acc,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  output logic [31:0]        mac_in1,
  output logic [31:0]        mac_in2,
  output logic [127:0]       mac_in3,
  output logic [1:0]         mac_mode,
  output logic [PARM_RM-1:0] mac_rm,
  input  logic [127:0]       mac_out,
  input  logic               mac_nv,
  input  logic               mac_of,
  input  logic               mac_uf,
  input  logic               mac_nx,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [3:0]         res_flags,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int WCNT_W = $clog2(MAC_LAT + 1);
  localparam logic [WCNT_W-1:0] WCNT_END = WCNT_W'(MAC_LAT);

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [PARM_RM-1:0] rm_q, rm_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [31:0]        acc_q, acc_d;
  logic [3:0]         flags_q, flags_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;

  // Only the low word of the MAC result carries the accumulator format.
  logic unused_mac_hi;
  assign unused_mac_hi = ^mac_out[127:32];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rm_d    = rm_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    a_d     = a_q;
    b_d     = b_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d  = mode;
        rm_d    = rm;
        rem_d   = len;
        acc_d   = init_acc;
        flags_d = 4'b0000;
        if (mode == 2'b11) begin
          acc_d   = 32'h0;
          flags_d = 4'b1000;
          state_d = S_DONE;
        end else if (len == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (in_valid) begin
        a_d     = in_a;
        b_d     = in_b;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (wcnt_q == WCNT_END) begin
        // MAC flags are only meaningful on the capture cycle.
        acc_d   = mac_out[31:0];
        flags_d = flags_q | {mac_nv, mac_of, mac_uf, mac_nx};
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_ISSUE;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      rm_q    <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rm_q    <= rm_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign in_ready  = (state_q == S_ISSUE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = acc_q;
  assign res_flags = flags_q;
  assign mac_in1   = a_q;
  assign mac_in2   = b_q;
  assign mac_in3   = {96'h0, acc_q};
  assign mac_mode  = mode_q;
  assign mac_rm    = rm_q;

endmodule

// File: tb/tb_mac_fp_dot_sequencer.sv
// Bench for mac_fp_dot_sequencer: a table-driven two-stage MAC stand-in and a
// result scoreboard fed at job issue and drained by a separate monitor.
module tb_mac_fp_dot_sequencer;
  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_ready, res_valid, res_ready, busy;
  logic [7:0]   len;
  logic [1:0]   mode, mac_mode;
  logic [2:0]   rm, mac_rm;
  logic [31:0]  init_acc, in_a, in_b, mac_in1, mac_in2, res_data;
  logic [127:0] mac_in3, mac_out;
  logic         mac_nv, mac_of, mac_uf, mac_nx;
  logic [3:0]   res_flags;

  int n_chk = 0, n_fail = 0, n_hs = 0, exp_hs = 0;
  logic [35:0] sb_q[$];
  logic [31:0] va[4], vb[4];

  always #5 clk = ~clk;

  mac_fp_dot_sequencer #(.PARM_RM(3), .MAC_LAT(2), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .rm(rm),
    .init_acc(init_acc), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_in1(mac_in1), .mac_in2(mac_in2),
    .mac_in3(mac_in3), .mac_mode(mac_mode), .mac_rm(mac_rm), .mac_out(mac_out),
    .mac_nv(mac_nv), .mac_of(mac_of), .mac_uf(mac_uf), .mac_nx(mac_nx),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .busy(busy)
  );

  // MAC stand-in: known a*b+c results, anything else returns junk with all flags set.
  function automatic logic [35:0] mac_ref(input logic [1:0] m, input logic [31:0] a, b, c);
    case ({m, a, b, c})
      {2'b10, 32'h3F800000, 32'h40000000, 32'h00000000}: return {4'b0000, 32'h40000000};
      {2'b10, 32'h40400000, 32'h3F000000, 32'h40000000}: return {4'b0000, 32'h40600000};
      {2'b00, 32'h00003C00, 32'h00004000, 32'h00003C00}: return {4'b0000, 32'h00004200};
      {2'b10, 32'h7F000000, 32'h40000000, 32'h00000000}: return {4'b0101, 32'h7F800000};
      {2'b10, 32'h3F800000, 32'h3F800000, 32'h7F800000}: return {4'b0000, 32'h7F800000};
      {2'b10, 32'h40000000, 32'h40400000, 32'h00000000}: return {4'b0000, 32'h40C00000};
      {2'b10, 32'h3F800000, 32'h3F800000, 32'h40C00000}: return {4'b0000, 32'h40E00000};
      {2'b10, 32'h40000000, 32'h40000000, 32'h00000000}: return {4'b0000, 32'h40800000};
      default: return {4'b1111, 32'hDEADBEEF};
    endcase
  endfunction

  logic [35:0] s1, s2;
  always @(posedge clk) begin
    s1 <= mac_ref(mac_mode, mac_in1, mac_in2, mac_in3[31:0]);
    s2 <= s1;
  end
  assign mac_out = {96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, s2[31:0]};
  assign {mac_nv, mac_of, mac_uf, mac_nx} = s2[35:32];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_flags"}, res_flags, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mac_in1"}, mac_in1, 0);
    chk({tag, "_mac_in2"}, mac_in2, 0);
    chk({tag, "_mac_in3"}, mac_in3, 0);
    chk({tag, "_mac_mode"}, mac_mode, 0);
    chk({tag, "_mac_rm"}, mac_rm, 0);
  endtask

  // Monitor: counts operand handshakes and checks every result handshake against the scoreboard.
  always @(negedge clk) begin
    if (in_valid && in_ready) n_hs++;
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        logic [35:0] e;
        e = sb_q.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_flags", res_flags, e[35:32]);
      end
    end
  end

  // toggle: in_valid every other cycle plus stray start pulses while busy.
  // abort_at>0: reset one cycle after that many operand handshakes.
  task automatic run_job(input string tag, input logic [1:0] m, input int n,
                         input logic [31:0] init, input logic [31:0] exp_d,
                         input logic [3:0] exp_f, input int exp_lat, input bit toggle,
                         input int stall, input int abort_at);
    int idx, cyc;
    bit hs;
    if (abort_at == 0) sb_q.push_back({exp_f, exp_d});
    exp_hs += (abort_at > 0) ? abort_at : ((m == 2'b11) ? 0 : n);
    start = 1'b1; mode = m; len = 8'(n); rm = 3'd0; init_acc = init;
    res_ready = (stall == 0);
    tick();
    start = 1'b0;
    cyc = 1; idx = 0;
    while (!res_valid && cyc < 300) begin
      start = toggle && (cyc == 3 || cyc == 6);
      mode  = start ? 2'b11 : m;
      in_valid = (idx < n) && (!toggle || cyc[0]);
      in_a = (idx < n) ? va[idx] : 32'h0;
      in_b = (idx < n) ? vb[idx] : 32'h0;
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) idx++;
      if (abort_at > 0 && hs && idx == abort_at) begin
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_reset({tag, "_abort"});
        rst = 1'b0;
        return;
      end
    end
    in_valid = 1'b0; start = 1'b0; mode = m;
    chk({tag, "_res_valid_seen"}, res_valid, 1);
    if (exp_lat >= 0) chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    for (int k = 0; k < stall; k++) begin
      start = toggle;
      chk({tag, "_stall_valid"}, res_valid, 1);
      chk({tag, "_stall_data"}, res_data, exp_d);
      chk({tag, "_stall_flags"}, res_flags, exp_f);
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, res_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; mode = '0; rm = '0; init_acc = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    va[0] = 32'h3F800000; vb[0] = 32'h40000000;
    va[1] = 32'h40400000; vb[1] = 32'h3F000000;
    run_job("fp32_sum", 2'b10, 2, 32'h0, 32'h40600000, 4'b0000, 9, 0, 0, 0);

    va[0] = 32'h00003C00; vb[0] = 32'h00004000;
    run_job("fp16", 2'b00, 1, 32'h00003C00, 32'h00004200, 4'b0000, 5, 0, 0, 0);

    run_job("len0", 2'b10, 0, 32'h12345678, 32'h12345678, 4'b0000, 1, 0, 0, 0);
    run_job("mode11", 2'b11, 3, 32'h12345678, 32'h0, 4'b1000, 1, 0, 0, 0);

    va[0] = 32'h7F000000; vb[0] = 32'h40000000;
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
    run_job("ovf", 2'b10, 2, 32'h0, 32'h7F800000, 4'b0101, 9, 0, 0, 0);

    va[0] = 32'h40000000; vb[0] = 32'h40400000;
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
    run_job("bp", 2'b10, 2, 32'h0, 32'h40E00000, 4'b0000, -1, 1, 5, 0);

    va[0] = 32'h7F000000; vb[0] = 32'h40000000;
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
    run_job("rst_mid", 2'b10, 2, 32'h0, 32'h0, 4'b0000, -1, 0, 0, 2);

    va[0] = 32'h40000000; vb[0] = 32'h40000000;
    run_job("post_rst", 2'b10, 1, 32'h0, 32'h40800000, 4'b0000, 5, 0, 0, 0);

    tick(); tick();
    chk("handshakes", n_hs, exp_hs);
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mac_fp_dot_sequencer.md
# mac_fp_dot_sequencer

Initiator that drives one MAC_FP unit to compute a dot product from a stream of operand pairs. It registers each pair, presents it to MAC_FP with the running accumulator on IN3, and waits out the MAC pipeline latency. It captures the result back into the accumulator, and after `len` products returns the final value with sticky exception flags on a valid/ready result port. It sits between a tensor-core operand fetcher and a MAC_FP instance; it owns the accumulator feedback that MAC_FP itself leaves to its user.

## Interface
- PARM_RM, 3: rounding-mode width; must match MAC_FP.
- MAC_LAT, 2: MAC_FP pipeline depth in cycles; must be ≥1.
- LEN_W, 8: width of the product-count field.

- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  LEN_W  number of products in the job; 0 is legal.
- mode  in  2  job mode: 00 = fp16, 01 = fp16 operands with fp32 accumulate, 10 = fp32, 11 = illegal.
- rm  in  PARM_RM  rounding mode for the job.
- init_acc  in  32  initial accumulator; fp16 in [15:0] when mode=00.
- in_valid / in_ready  in / out  1  operand handshake.
- in_a, in_b  in  32  operands; fp16 in [15:0] for modes 00/01.
- mac_in1, mac_in2  out  32  to MAC_FP IN1/IN2; in_a goes to mac_in1, in_b to mac_in2.
- mac_in3  out  128  to MAC_FP IN3, driven as {96'b0, acc}.
- mac_mode  out  2  to MAC_FP mode.
- mac_rm  out  PARM_RM  to MAC_FP rounding mode.
- mac_out  in  128  from MAC_FP OUT; only [31:0] is used.
- mac_nv, mac_of, mac_uf, mac_nx  in  1  MAC_FP exception flags.
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  32  final accumulator.
- res_flags  out  4  sticky flags {NV, OF, UF, NX}.
- busy  out  1  high in any state other than IDLE.

## Operation
- State machine has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE, on start=1:
  - Latch mode, rm and len into mode_q, rm_q and rem.
  - Set acc = init_acc and clear the sticky flags.
  - If mode=11, set acc=0 and flags=4'b1000, then go to DONE.
  - Otherwise, if len=0, go to DONE with acc=init_acc.
  - Otherwise go to ISSUE.
- ISSUE: in_ready=1. On in_valid&&in_ready, register in_a and in_b into the operand registers, clear wait counter wcnt, and go to WAIT.
- WAIT: mac_in1/2/3, mac_mode and mac_rm are held stable. wcnt increments every cycle. On the cycle where wcnt==MAC_LAT:
  - acc <= mac_out[31:0].
  - flags |= {mac_nv, mac_of, mac_uf, mac_nx}.
  - rem <= rem-1.
  - Go to DONE if rem==1, else go to ISSUE.
- DONE: res_valid=1, res_data=acc, res_flags=flags. On res_ready, go to IDLE. Outputs stay stable while res_ready is low.
- Flags are ORed only on capture cycles; MAC flag values in other cycles are ignored.
- mac_mode = mode_q and mac_rm = rm_q for the whole job. No format conversion happens here; MAC_FP does it.
- start outside IDLE is ignored. in_ready is 0 outside ISSUE.

## Timing
- Reset values: state=IDLE, in_ready=0, res_valid=0, res_data=0, res_flags=0, busy=0, mac_in1=0, mac_in2=0, mac_in3=0, mac_mode=0, mac_rm=0. Internally acc=0 and rem=0.
- Reset asserted in any state returns to IDLE on the next edge. A partial job is discarded, with no res_valid pulse.
- Operands accepted at edge t are presented on mac_in* from cycle t+1. The capture happens at the end of cycle t+1+MAC_LAT.
- Per-element period is MAC_LAT+2 cycles with in_valid held high; this is 4 cycles at MAC_LAT=2.
- Latency with len=N and continuous input: res_valid rises N·(MAC_LAT+2)+1 cycles after the start edge.
- len=0 or mode=11: res_valid is high in the cycle after the start edge.
- A new start is accepted no earlier than the cycle after the res_valid&&res_ready handshake; there is no start/result overlap.
- rem decrement and the DONE transition occur on the same edge; rem never wraps.
- in_valid dropping during ISSUE stalls in ISSUE indefinitely.

## Test plan
All tests use MAC_LAT=2 with a real MAC_FP attached and rm=0 (RNE).
- fp32, len=2, init_acc=0: pairs (0x3F800000, 0x40000000) and (0x40400000, 0x3F000000). Required: res_data=0x40600000 (3.5), res_flags=0, res_valid 9 cycles after start.
- fp16, len=1, init_acc=0x3C00, pair (0x3C00, 0x4000). Required: res_data[15:0]=0x4200 (3.0), flags=0.
- len=0, init_acc=0x12345678. Required: res_valid the next cycle, res_data=0x12345678, flags=0, in_ready never high. With mode=11 instead: res_data=0, res_flags=4'b1000.
- fp32 overflow, len=2, init_acc=0: pairs (0x7F000000, 0x40000000) then (0x3F800000, 0x3F800000). Required: res_data=0x7F800000, and res_flags has OF and NX set and held sticky.
- Backpressure: in_valid toggling every other cycle, and res_ready low for 5 cycles in DONE. Required: correct sum, res_data/res_flags stable while stalled, no extra in_ready handshakes, and start ignored while busy.
- rst pulsed during WAIT of element 2. Required: next cycle all outputs are at reset values. A following len=1 job is then correct and unaffected by the old acc or flags.
